// File: rtl/lsu_axi_pkg.sv
// Shared types and encodings for the LSU AXI4-Lite initiator and its lane aligner.
package lsu_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_DONE
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Anything other than a plain OKAY is reported back to the pipeline as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != OKAY;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for a 32-bit data bus: store strobes/shift, load extract/extend,
// and alignment check. Purely combinational.
module lsu_lane_align
  import lsu_axi_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [31:0] rdata_sh;

  assign wdata_sh = wdata << {off, 3'b000};
  assign rdata_sh = rdata >> {off, 3'b000};

  always_comb begin
    wstrb      = 4'b1111;
    rdata_ext  = rdata;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        wstrb     = 4'b0001 << off;
        rdata_ext = is_unsigned ? {24'h0, rdata_sh[7:0]}
                                : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      end
      SZ_H: begin
        wstrb      = 4'b0011 << off;
        rdata_ext  = is_unsigned ? {16'h0, rdata_sh[15:0]}
                                 : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
        misaligned = off[0];
      end
      SZ_W: begin
        misaligned = (off != 2'b00);
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lsu_axi_master.sv
// LSU AXI4-Lite initiator: one load/store at a time, min 3 cycles accept->resp_valid,
// misaligned requests complete in 1 cycle with err; resp held until resp_ready.
module lsu_axi_master
  import lsu_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,

  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,

  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,

  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,

  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,

  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [3:0]            wstrb,

  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp
);

  state_t                state;
  state_t                state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [3:0]            wstrb_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  aw_done;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  idle;
  logic [1:0]            al_size;
  logic                  al_uns;
  logic [1:0]            al_off;
  logic [3:0]            al_wstrb;
  logic [DATA_WIDTH-1:0] al_wdata_sh;
  logic [DATA_WIDTH-1:0] al_rdata_ext;
  logic                  al_misaligned;

  assign idle   = (state == S_IDLE);
  assign accept = req_valid && req_ready;

  // The aligner sees the live request while idle (alignment check, store lane
  // steering captured at accept) and the registered request afterwards (load extract).
  assign al_size = idle ? req_size       : size_q;
  assign al_uns  = idle ? req_unsigned   : uns_q;
  assign al_off  = idle ? req_addr[1:0]  : addr_q[1:0];

  lsu_lane_align u_align (
    .size        (al_size),
    .is_unsigned (al_uns),
    .off         (al_off),
    .wdata       (req_wdata),
    .rdata       (rdata),
    .wstrb       (al_wstrb),
    .wdata_sh    (al_wdata_sh),
    .rdata_ext   (al_rdata_ext),
    .misaligned  (al_misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    rready     = 1'b0;
    bready     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (al_misaligned) state_next = S_DONE;
          else if (req_wen)  state_next = S_WR_REQ;
          else               state_next = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_next = S_DONE;
      end
      S_WR_REQ: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_next = S_WR_RESP;
      end
      S_WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_next = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wstrb_q <= 4'b0000;
      wdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wstrb_q <= al_wstrb;
        wdata_q <= al_wdata_sh;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        rdata_q <= '0;
        err_q   <= al_misaligned;
      end
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready)   w_done  <= 1'b1;
      if (rready && rvalid) begin
        rdata_q <= al_rdata_ext;
        err_q   <= resp_is_err(rresp);
      end
      if (bready && bvalid) begin
        rdata_q <= '0;
        err_q   <= resp_is_err(bresp);
      end
    end
  end

  assign araddr     = addr_q;
  assign awaddr     = addr_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // A raised valid must stay up with stable payload until its handshake.
  ar_hold: assert property (@(posedge clk)
    (rst && arvalid && !arready) |=> (arvalid && $stable(araddr)));
  aw_hold: assert property (@(posedge clk)
    (rst && awvalid && !awready) |=> (awvalid && $stable(awaddr)));
  w_hold: assert property (@(posedge clk)
    (rst && wvalid && !wready) |=> (wvalid && $stable(wdata) && $stable(wstrb)));

endmodule
